drap_branch_target: RTL and testbench
=====================================

# drap_branch_target

Pipelined, parametrised control-transfer target generator for the MIPS datapath. It takes the place of the fixed 30-to-32-bit shift-left-2 stage and the separate branch adder. It computes the branch (PC-relative), jump (region-concatenated), register and sequential targets with a configurable shift amount and widths. The block is a two-stage valid/ready pipeline between decode and the fetch PC mux, with stall and flush support.

## Interface

Parameters:
- AW, 32, address width.
- IW, 16, branch immediate width; sign-extended to AW.
- JW, 26, jump index width; constraint IW <= JW and JW+SHAMT <= AW.
- SHAMT, 2, left-shift applied to the immediate and the jump index; 0 is legal.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous kill of all in-flight entries.
- in_valid, input, 1, request present.
- in_ready, output, 1, request accepted when in_valid && in_ready.
- mode, input, 2, transfer type: 00 branch, 01 jump, 10 register, 11 sequential.
- pc_plus4, input, AW, address of the following instruction.
- imm, input, JW, jump index; the branch uses imm[IW-1:0].
- rs_val, input, AW, register operand for mode 10.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts when out_valid && out_ready.
- target, output, AW, computed target.
- out_misalign, output, 1, present only with DRAP_MISALIGN_CHK_EN.

## Operation

- Stage 1 (S1) registers the mode and pc_plus4, plus one precomputed operand:
  - branch: sext(imm[IW-1:0]) << SHAMT, truncated to AW.
  - jump: {pc_plus4[AW-1:JW+SHAMT], imm, SHAMT'b0}.
  - register: rs_val.
  - sequential: pc_plus4.
- Stage 2 (S2) registers target:
  - branch: S1.pc + S1.operand, modulo 2^AW, with carry discarded.
  - all other modes: S1.operand.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - in_ready does not depend on in_valid.
- A stage's data registers load only when that stage advances with a valid entry. The contents of a stage whose valid bit is 0 are don't-care and are not checked.
- Order is strictly FIFO. There are no bubbles when both sides are continuously ready.
- While out_valid && !out_ready, target and out_misalign hold stable.
- flush: s1_valid and s2_valid clear at the next edge. A request presented in the same cycle as flush is dropped, although in_ready is still computed normally. The output handshake in the flush cycle still completes if out_ready is high.
- rst has priority over flush and over all handshakes.

## Timing

- Latency: accepted at edge N, out_valid at edge N+2 with no stall.
- Throughput: 1 request per clock.
- Capacity: 2 entries. With out_ready held low, the third request stalls: in_ready stays 0 once both stages are full.
- Reset values:
  - out_valid = 0, in_ready = 1 (after the reset cycle), target = 0, out_misalign = 0.
  - Internal valid bits = 0.
- Reset mid-operation discards all entries with no partial output.
- Simultaneous events when full: an output accept and an input accept in the same cycle is legal. Both stages shift and the pipeline remains full.
- No combinational path exists from in_valid or data inputs to the outputs. The only combinational path is out_ready -> in_ready.

## Configuration

- DRAP_MISALIGN_CHK_EN defined:
  - out_misalign is registered alongside target in S2.
  - out_misalign = 1 when target[SHAMT-1:0] != 0 in register mode; it is 0 for all other modes.
  - When SHAMT = 0, out_misalign is tied to 0.
- DRAP_MISALIGN_CHK_EN undefined:
  - The out_misalign port does not exist.
  - There is no related logic; all other behaviour is identical.

## Test plan

- Branch, default parameters: pc_plus4=0x00400004 with imm=0x0000FFFF gives target=0x00400000; with imm=0x00000003 it gives target=0x00400010. Each result appears exactly 2 cycles after acceptance.
- Jump: pc_plus4=0x10000004, imm=0x0100000 gives target=0x10400000. Wrap case: a branch with pc_plus4=0xFFFFFFFC and imm=0x0001 gives target=0x00000000.
- Backpressure: out_ready=0 while requests A, B, C are offered back-to-back. A and B are accepted, in_ready falls, C is held. Then raise out_ready; the outputs must appear in the order A, B, C with one per cycle and nothing lost or duplicated.
- Flush: with both stages full and a new request offered, assert flush for one cycle. Next cycle out_valid=0, the offered request never appears, and in_ready=1.
- Reset mid-stream: assert rst for one cycle while out_valid=1 and out_ready=0. Next cycle out_valid=0 and target=0, and the next request has 2-cycle latency.
- With DRAP_MISALIGN_CHK_EN: register mode with rs_val=0x00400123 gives out_misalign=1; with rs_val=0x00400120 it gives out_misalign=0. A branch to a misaligned-looking sum gives out_misalign=0. Also build without the macro and confirm the port is absent.

Source files
------------

// File: rtl/drap_branch_target.sv
// drap_branch_target: two-stage valid/ready generator for branch, jump, register and sequential targets.
// Optional build macro DRAP_MISALIGN_CHK_EN adds the registered out_misalign flag for register-mode targets.
module drap_branch_target #(
    parameter int AW    = 32,
    parameter int IW    = 16,
    parameter int JW    = 26,
    parameter int SHAMT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] pc_plus4,
    input  logic [JW-1:0] imm,
    input  logic [AW-1:0] rs_val,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef DRAP_MISALIGN_CHK_EN
    output logic          out_misalign,
`endif
    output logic [AW-1:0] target
);

    localparam logic [1:0]    MODE_BR  = 2'b00;
    localparam logic [1:0]    MODE_JMP = 2'b01;
    localparam logic [1:0]    MODE_REG = 2'b10;
    localparam logic [1:0]    MODE_SEQ = 2'b11;

    localparam logic [AW-1:0] ONES        = {AW{1'b1}};
    // Upper address bits kept from pc_plus4 on a jump; empty when JW+SHAMT == AW.
    localparam logic [AW-1:0] REGION_MASK = ONES << (JW + SHAMT);

    logic          s1_valid;
    logic [1:0]    s1_mode;
    logic [AW-1:0] s1_pc;
    logic [AW-1:0] s1_op;
    logic          s2_valid;
    logic          s1_adv;
    logic          s2_adv;

    logic [AW-1:0] br_off;
    logic [AW-1:0] jmp_tgt;
    logic [AW-1:0] op_next;
    logic [AW-1:0] tgt_next;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign br_off  = AW'($signed(imm[IW-1:0])) << SHAMT;
    assign jmp_tgt = (pc_plus4 & REGION_MASK) | (AW'(imm) << SHAMT);

    always_comb begin
        op_next = pc_plus4;
        case (mode)
            MODE_BR:  op_next = br_off;
            MODE_JMP: op_next = jmp_tgt;
            MODE_REG: op_next = rs_val;
            MODE_SEQ: op_next = pc_plus4;
            default:  op_next = pc_plus4;
        endcase
    end

    assign tgt_next = (s1_mode == MODE_BR) ? (s1_pc + s1_op) : s1_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_mode <= mode;
            s1_pc   <= pc_plus4;
            s1_op   <= op_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
        end else if (s2_adv && s1_valid) begin
            target <= tgt_next;
        end
    end

`ifdef DRAP_MISALIGN_CHK_EN
    // Low-bit mask is all zeros when SHAMT == 0, which ties the flag low.
    localparam logic [AW-1:0] LOW_MASK = ~(ONES << SHAMT);
    logic mis_next;

    assign mis_next = (s1_mode == MODE_REG) && (|(s1_op & LOW_MASK));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_misalign <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            out_misalign <= mis_next;
        end
    end
`endif

endmodule

// File: tb/tb_drap_branch_target.sv
// Scoreboard bench for drap_branch_target (default parameters); builds with or without DRAP_MISALIGN_CHK_EN.
module tb_drap_branch_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [31:0] pc_plus4;
    logic [25:0] imm;
    logic [31:0] rs_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] target;
`ifdef DRAP_MISALIGN_CHK_EN
    logic        out_misalign;
`endif

    drap_branch_target dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .pc_plus4  (pc_plus4),
        .imm       (imm),
        .rs_val    (rs_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DRAP_MISALIGN_CHK_EN
        .out_misalign (out_misalign),
`endif
        .target    (target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic lat_mode = 1'b0;
    logic rnd_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: targets from the architectural definitions with plain integer arithmetic.
    function automatic exp_t ref_model(input logic [1:0] m, input logic [31:0] pc,
                                       input logic [25:0] im, input logic [31:0] rs);
        exp_t   r;
        longint off;
        r.mis = 1'b0;
        r.cyc = 0;
        r.t   = pc;
        case (m)
            2'd0: begin
                off = longint'(im[15:0]);
                if (off >= 32768) off = off - 65536;
                r.t = 32'((longint'(pc) + off * 4) & 64'h0000_0000_FFFF_FFFF);
            end
            2'd1: r.t = (pc & 32'hF000_0000) | (32'(im) * 32'd4);
            2'd2: begin
                r.t   = rs;
                r.mis = (rs % 4) != 0;
            end
            default: r.t = pc;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got target %h with empty scoreboard", target);
            end else begin
                e = sb.pop_front();
                check("target", target, e.t);
`ifdef DRAP_MISALIGN_CHK_EN
                check("out_misalign", 32'(out_misalign), 32'(e.mis));
`endif
                if (lat_mode) check("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_phase) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drive(input logic [1:0] m, input logic [31:0] pc,
                         input logic [25:0] im, input logic [31:0] rs);
        in_valid = 1'b1;
        mode     = m;
        pc_plus4 = pc;
        imm      = im;
        rs_val   = rs;
    endtask

    // Waits (bounded) for the offered request to be accepted; pushes the expectation at acceptance.
    task automatic wait_accept(input logic use_exp, input logic [31:0] et, input logic em);
        exp_t e;
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !flush && !rst) begin
                e = ref_model(mode, pc_plus4, imm, rs_val);
                if (use_exp) begin
                    e.t   = et;
                    e.mis = em;
                end
                e.cyc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready %b expected 1 within 100 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [1:0] m, input logic [31:0] pc, input logic [25:0] im,
                            input logic [31:0] rs, input logic [31:0] et, input logic em);
        drive(m, pc, im, rs);
        wait_accept(1'b1, et, em);
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] pc,
                        input logic [25:0] im, input logic [31:0] rs);
        drive(m, pc, im, rs);
        wait_accept(1'b0, 32'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'd0; pc_plus4 = '0; imm = '0; rs_val = '0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_target", target, 32'd0);
`ifdef DRAP_MISALIGN_CHK_EN
        check("reset_misalign", 32'(out_misalign), 32'd0);
`endif
        @(posedge clk); #1;

        // Directed vectors, continuous ready: exact 2-cycle latency
        lat_mode = 1'b1;
        send_exp(2'd0, 32'h0040_0004, 26'h000_FFFF, 32'h0, 32'h0040_0000, 1'b0);
        send_exp(2'd0, 32'h0040_0004, 26'h000_0003, 32'h0, 32'h0040_0010, 1'b0);
        send_exp(2'd1, 32'h1000_0004, 26'h010_0000, 32'h0, 32'h1040_0000, 1'b0);
        send_exp(2'd0, 32'hFFFF_FFFC, 26'h000_0001, 32'h0, 32'h0000_0000, 1'b0);
        send_exp(2'd3, 32'h0040_0008, 26'h3FF_FFFF, 32'h0, 32'h0040_0008, 1'b0);
`ifdef DRAP_MISALIGN_CHK_EN
        send_exp(2'd2, 32'h0, 26'h0, 32'h0040_0123, 32'h0040_0123, 1'b1);
        send_exp(2'd2, 32'h0, 26'h0, 32'h0040_0120, 32'h0040_0120, 1'b0);
        send_exp(2'd0, 32'h0040_0005, 26'h000_0000, 32'h0, 32'h0040_0005, 1'b0);
`else
        send_exp(2'd2, 32'h0, 26'h0, 32'h0040_0123, 32'h0040_0123, 1'b0);
`endif
        idle(4);
        lat_mode = 1'b0;

        // Backpressure: A, B fill the pipe, C stalls
        out_ready = 1'b0;
        send(2'd0, 32'h0000_1000, 26'h000_0010, 32'h0);
        send(2'd2, 32'h0, 26'h0, 32'hA5A5_0004);
        drive(2'd1, 32'h2000_0000, 26'h123_4567, 32'h0);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_still_stalled", 32'(in_ready), 32'd0);
        check("bp_target_hold_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(1'b0, 32'd0, 1'b0);
        idle(4);
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Flush with both stages full and a request offered
        out_ready = 1'b0;
        send(2'd3, 32'h0000_2000, 26'h0, 32'h0);
        send(2'd3, 32'h0000_3000, 26'h0, 32'h0);
        drive(2'd3, 32'h0000_4000, 26'h0, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(4);

        // Flush with ready pipe: the offered request is dropped despite in_ready
        drive(2'd3, 32'h0000_5000, 26'h0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready_normal", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        idle(4);

        // Reset mid-stream
        out_ready = 1'b0;
        send(2'd3, 32'h0000_6000, 26'h0, 32'h0);
        send(2'd3, 32'h0000_7000, 26'h0, 32'h0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_target", target, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        lat_mode = 1'b1;
        send(2'd0, 32'h0040_0004, 26'h000_0003, 32'h0);
        idle(4);
        lat_mode = 1'b0;

        // Randomized traffic with random backpressure and occasional flush
        rnd_phase = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] rs;
            rs = $urandom();
            if ($urandom_range(0, 1) == 0) rs = rs & 32'hFFFF_FFFC;
            if ($urandom_range(0, 39) == 0) begin
                drive(2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC, 26'($urandom()), rs);
                in_valid = 1'($urandom_range(0, 1));
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                in_valid = 1'b0;
                sb.delete();
            end else begin
                send(2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC, 26'($urandom()), rs);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rnd_phase = 1'b0;
        #2;
        out_ready = 1'b1;
        idle(10);
        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
